// File: rtl/path_mon_pkg.sv
// path_mon_pkg: shared FSM state type and width helpers for the path delay monitor
package path_mon_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, DONE} monState;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sumW(input int cntW, input int numTrials);
    return cntW + clog2(numTrials);
  endfunction
endpackage

// File: rtl/path_delay_monitor_sync_chain.sv
// sync_chain: reset-to-zero flop chain bringing an asynchronous level into clk
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  (* keep = "true" *) logic [STAGES-1:0] flops;
  always_ff @(posedge clk)
    flops <= rst ? '0 : {flops[STAGES-2:0], d};
  assign q = flops[STAGES-1];
endmodule

// File: rtl/path_delay_monitor.sv
// path_delay_monitor: launches alternating edges into a delay path, times their synchronised
// arrival over NUM_TRIALS launches and flags sums above a golden threshold or timeouts.
module path_delay_monitor import path_mon_pkg::*; #(
  parameter int NUM_TRIALS     = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int SETTLE_CYCLES  = 4,
  parameter int PATH_INVERTING = 1,
  parameter int SYNC_STAGES    = 2,
  localparam int TW            = clog2(NUM_TRIALS),
  localparam int SUM_W         = sumW(CNT_W, NUM_TRIALS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] threshold,
  output logic             path_input,
  input  logic             path_result,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] delay_sum,
  output logic [CNT_W-1:0] delay_avg,
  output logic             timeout,
  output logic             alarm
);
  localparam int STW = clog2(SETTLE_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    TRIAL_LAST  = TW'(NUM_TRIALS - 1);
  localparam logic [STW-1:0]   SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
  localparam logic             INV_BIT     = PATH_INVERTING != 0;
  monState state;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0] trial;
  logic [STW-1:0] settleCnt;
  logic syncOut, expLevel;
  sync_chain #(.STAGES(SYNC_STAGES)) uSync (
    .clk(clk),
    .rst(rst),
    .d(path_result),
    .q(syncOut)
  );
  // path_input already holds the new launch level while in WAIT
  assign expLevel  = path_input ^ INV_BIT;
  assign delay_avg = delay_sum[SUM_W-1:TW];
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      path_input <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      delay_sum  <= '0;
      timeout    <= 1'b0;
      alarm      <= 1'b0;
      cnt        <= '0;
      trial      <= '0;
      settleCnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            delay_sum <= '0;
            timeout   <= 1'b0;
            alarm     <= 1'b0;
            trial     <= '0;
            busy      <= 1'b1;
            state     <= LAUNCH;
          end
        LAUNCH: begin
          path_input <= ~path_input;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT:
          if (syncOut == expLevel) begin
            delay_sum <= delay_sum + {{TW{1'b0}}, cnt};
            settleCnt <= '0;
            state     <= (trial == TRIAL_LAST) ? DONE : SETTLE;
            done      <= trial == TRIAL_LAST;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= DONE;
            done    <= 1'b1;
          end else
            cnt <= cnt + 1'b1;
        SETTLE:
          if (settleCnt == SETTLE_LAST) begin
            trial <= trial + 1'b1;
            state <= LAUNCH;
          end else
            settleCnt <= settleCnt + 1'b1;
        DONE: begin
          busy  <= 1'b0;
          alarm <= timeout | (delay_sum > threshold);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_path_delay_monitor.sv
// tb_path_delay_monitor: directed and randomized checks of the delay monitor against a trial-level model
module tb_path_delay_monitor;
  localparam int NT = 16, CW = 8, SS = 2, SW = CW + 4;
  logic clk = 0, rst = 1, start = 0, startN = 0, stuck = 0;
  logic [SW-1:0] threshold = '0;
  logic pin, pinN, busy, busyN, done, doneN, tmo, tmoN, alarm, alarmN, pres, presN;
  logic [SW-1:0] sum, sumN;
  logic [CW-1:0] avg, avgN;
  logic [3:0] pipe;
  int delay = 0, total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pipe <= {pipe[2:0], pin};
  assign pres  = stuck ? 1'b0 : ~(delay == 0 ? pin : pipe[delay-1]);
  assign presN = pinN;

  path_delay_monitor dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .path_input(pin), .path_result(pres), .busy(busy), .done(done),
    .delay_sum(sum), .delay_avg(avg), .timeout(tmo), .alarm(alarm)
  );
  path_delay_monitor #(.PATH_INVERTING(0)) dutN (
    .clk(clk), .rst(rst), .start(startN), .threshold(threshold),
    .path_input(pinN), .path_result(presN), .busy(busyN), .done(doneN),
    .delay_sum(sumN), .delay_avg(avgN), .timeout(tmoN), .alarm(alarmN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stuck-low path: sync already holds 0, so a trial expecting 0 lands at cnt=0, one expecting 1 times out
  function automatic int stuckModel(output bit tmoOut);
    int s = 0;
    bit p = 0;
    tmoOut = 0;
    for (int t = 0; t < NT; t++) begin
      p = ~p;
      if ((p ^ 1'b1) != 1'b0) begin
        tmoOut = 1;
        break;
      end
    end
    return s;
  endfunction

  task automatic measure(input bit n, input bit poke, input int expSum, input bit expTmo,
                         input logic [SW-1:0] thr);
    int cyc = 0, tog = 0, dn = 0;
    logic prev;
    threshold = thr;
    repeat (6) @(negedge clk);
    if (n) startN = 1; else start = 1;
    @(negedge clk);
    start = 0;
    startN = 0;
    chk("busy_rise", n ? busyN : busy, 1);
    prev = n ? pinN : pin;
    while (!(n ? doneN : done) && cyc < 5000) begin
      start = poke && cyc == 40;
      @(negedge clk);
      cyc++;
      if ((n ? pinN : pin) !== prev) begin
        tog++;
        prev = n ? pinN : pin;
      end
    end
    chk("done_seen", cyc < 5000, 1);
    start = poke;
    @(negedge clk);
    start = 0;
    chk("done_width", n ? doneN : done, 0);
    chk("busy_fall", n ? busyN : busy, 0);
    chk("delay_sum", n ? sumN : sum, expSum);
    chk("delay_avg", n ? avgN : avg, expSum / NT);
    chk("timeout", n ? tmoN : tmo, expTmo);
    chk("alarm", n ? alarmN : alarm, expTmo | (expSum > int'(thr)));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (n ? doneN : done) dn++;
    end
    chk("extra_done", dn, 0);
    chk("idle_busy", n ? busyN : busy, 0);
    if (n) chk("toggles", tog, NT);
  endtask

  initial begin
    int tog, cyc, expS, thr;
    bit expT;
    logic prev;
    repeat (5) @(negedge clk);
    chk("rst_pin", pin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_alarm", alarm, 0);
    rst = 0;
    delay = 0;
    measure(0, 0, NT * SS, 0, 40);
    delay = 3;
    measure(0, 0, NT * (SS + 3), 0, 79);
    measure(0, 0, NT * (SS + 3), 0, 80);
    for (int i = 0; i < 4; i++) begin
      delay = $urandom_range(0, 4);
      expS = NT * (SS + delay);
      thr = expS - 2 + $urandom_range(0, 4);
      measure(0, 0, expS, 0, SW'(thr));
    end
    delay = 1;
    measure(0, 1, NT * (SS + 1), 0, 100);
    delay = 3;
    repeat (6) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    tog = 0;
    cyc = 0;
    prev = pin;
    while (tog < 8 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pin !== prev) begin
        tog++;
        prev = pin;
      end
    end
    chk("trial7_reached", tog, 8);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_pin", pin, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("mid_rst_idle", busy, 0);
    measure(0, 0, NT * (SS + 3), 0, 200);
    stuck = 1;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    expS = stuckModel(expT);
    measure(0, 0, expS, expT, 500);
    stuck = 0;
    measure(1, 0, NT * SS, 0, 40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
